// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- fetch-PC generator for the core front end.
//
// Holds the fetch address, advances it by FETCH_BYTES every unstalled cycle
// and applies redirects from three ranked sources (exception > ERET > branch).
// A redirect seen while stalled is parked in a one-entry pending slot and
// applied on the first unstalled cycle.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   -> pc_adel flags a misaligned redirect target at load time
//   undefined -> pc_adel is tied to 0 and no check logic exists
//
// Ports:
//   clk          in   clock, rising edge
//   resetn       in   asynchronous active-low reset
//   stall        in   hold pc_out; redirects go to the pending slot
//   exc_valid    in   exception redirect request (rank 3)
//   exc_target   in   exception handler address
//   eret_valid   in   ERET redirect request (rank 2)
//   eret_target  in   EPC value
//   br_valid     in   branch/jump redirect request (rank 1)
//   br_target    in   branch target
//   pc_out       out  current fetch address (registered)
//   redirected   out  one-cycle pulse: pc_out was just loaded from a redirect
//   pend_valid   out  pending slot occupied
//   pc_adel      out  misaligned-fetch flag (registered)
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hbfc00000,
    parameter int                FETCH_BYTES  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_target,
    input  logic              eret_valid,
    input  logic [ADDR_W-1:0] eret_target,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic              redirected,
    output logic              pend_valid,
    output logic              pc_adel
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              red_q, red_d;
    logic [1:0]        prank_q, prank_d;   // 0 = slot empty
    logic [ADDR_W-1:0] ptgt_q, ptgt_d;

    logic [1:0]        cur_rank;
    logic [ADDR_W-1:0] cur_tgt;
    logic              take_cur;
    logic [1:0]        cand_rank;
    logic [ADDR_W-1:0] cand_tgt;

    // Highest-ranked live request this cycle.
    always_comb begin
        cur_rank = 2'd0;
        cur_tgt  = '0;
        if (exc_valid) begin
            cur_rank = 2'd3;
            cur_tgt  = exc_target;
        end else if (eret_valid) begin
            cur_rank = 2'd2;
            cur_tgt  = eret_target;
        end else if (br_valid) begin
            cur_rank = 2'd1;
            cur_tgt  = br_target;
        end
    end

    // Live request beats pending on equal rank since it is the newer one.
    assign take_cur  = (cur_rank != 2'd0) && (cur_rank >= prank_q);
    assign cand_rank = take_cur ? cur_rank : prank_q;
    assign cand_tgt  = take_cur ? cur_tgt  : ptgt_q;

    always_comb begin
        pc_d    = pc_q;
        red_d   = 1'b0;
        prank_d = prank_q;
        ptgt_d  = ptgt_q;
        if (stall) begin
            if (take_cur) begin
                prank_d = cur_rank;
                ptgt_d  = cur_tgt;
            end
        end else if (cand_rank != 2'd0) begin
            pc_d    = cand_tgt;
            red_d   = 1'b1;
            prank_d = 2'd0;
            ptgt_d  = '0;
        end else begin
            pc_d = pc_q + ADDR_W'(FETCH_BYTES);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q    <= RESET_VECTOR;
            red_q   <= 1'b0;
            prank_q <= 2'd0;
            ptgt_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            red_q   <= red_d;
            prank_q <= prank_d;
            ptgt_q  <= ptgt_d;
        end
    end

    assign pc_out     = pc_q;
    assign redirected = red_q;
    assign pend_valid = (prank_q != 2'd0);

`ifdef PC_ALIGN_CHECK_EN
    localparam int OFF_W = $clog2(FETCH_BYTES);

    logic adel_q, adel_d;

    // Flag tracks pc_out: set/cleared on every load, held across stalls.
    always_comb begin
        adel_d = adel_q;
        if (!stall) begin
            if (cand_rank != 2'd0) adel_d = |cand_tgt[OFF_W-1:0];
            else                   adel_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) adel_q <= 1'b0;
        else         adel_q <= adel_d;
    end

    assign pc_adel = adel_q;
`else
    assign pc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen.
// Two instances share all inputs: u4 (FETCH_BYTES=4) and u8 (FETCH_BYTES=8).
// A behavioural model per instance is checked against the DUTs every negedge;
// directed steps additionally pin hand-computed values.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        stall = 1'b0;
    logic        exc_valid = 1'b0, eret_valid = 1'b0, br_valid = 1'b0;
    logic [31:0] exc_target = '0, eret_target = '0, br_target = '0;

    logic [31:0] pc4, pc8;
    logic        red4, red8, pv4, pv8, adel4, adel8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .RESET_VECTOR(32'hbfc00000), .FETCH_BYTES(4)) u4 (
        .clk(clk), .resetn(resetn), .stall(stall),
        .exc_valid(exc_valid), .exc_target(exc_target),
        .eret_valid(eret_valid), .eret_target(eret_target),
        .br_valid(br_valid), .br_target(br_target),
        .pc_out(pc4), .redirected(red4), .pend_valid(pv4), .pc_adel(adel4)
    );

    pc_gen #(.ADDR_W(32), .RESET_VECTOR(32'hbfc00000), .FETCH_BYTES(8)) u8 (
        .clk(clk), .resetn(resetn), .stall(stall),
        .exc_valid(exc_valid), .exc_target(exc_target),
        .eret_valid(eret_valid), .eret_target(eret_target),
        .br_valid(br_valid), .br_target(br_target),
        .pc_out(pc8), .redirected(red8), .pend_valid(pv8), .pc_adel(adel8)
    );

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    // ---------------- behavioural model ----------------
    // Pending entry is kept as (rank, target); the loaded PC is whichever of
    // {pending entry, this cycle's requests} has the highest rank, newest wins.
    logic [31:0] m_pc  [2] = '{32'hbfc00000, 32'hbfc00000};
    logic        m_red [2] = '{1'b0, 1'b0};
    logic        m_adel[2] = '{1'b0, 1'b0};
    int          m_prank[2] = '{0, 0};
    logic [31:0] m_ptgt [2] = '{32'h0, 32'h0};
    int          fb     [2] = '{4, 8};

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                m_pc[i] = 32'hbfc00000; m_red[i] = 0; m_adel[i] = 0;
                m_prank[i] = 0; m_ptgt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int          rk;
                logic [31:0] tg;
                int          best_rk;
                logic [31:0] best_tg;
                rk = 0; tg = 0;
                if (br_valid)   begin rk = 1; tg = br_target;   end
                if (eret_valid) begin rk = 2; tg = eret_target; end
                if (exc_valid)  begin rk = 3; tg = exc_target;  end
                best_rk = m_prank[i]; best_tg = m_ptgt[i];
                if (rk != 0 && rk >= best_rk) begin
                    best_rk = rk; best_tg = tg;
                    if (stall) begin m_prank[i] = rk; m_ptgt[i] = tg; end
                end
                m_red[i] = 0;
                if (!stall) begin
                    if (best_rk != 0) begin
                        m_pc[i]  = best_tg;
                        m_red[i] = 1;
                        m_adel[i] = ALIGN_EN && ((best_tg % fb[i]) != 0);
                    end else begin
                        m_pc[i]  = m_pc[i] + fb[i];
                        m_adel[i] = 0;
                    end
                    m_prank[i] = 0; m_ptgt[i] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model.
    always @(negedge clk) begin
        chk("mdl pc4",   pc4,   m_pc[0]);
        chk("mdl red4",  {31'b0, red4},  {31'b0, m_red[0]});
        chk("mdl pv4",   {31'b0, pv4},   {31'b0, m_prank[0] != 0});
        chk("mdl adel4", {31'b0, adel4}, {31'b0, m_adel[0]});
        chk("mdl pc8",   pc8,   m_pc[1]);
        chk("mdl red8",  {31'b0, red8},  {31'b0, m_red[1]});
        chk("mdl pv8",   {31'b0, pv8},   {31'b0, m_prank[1] != 0});
        chk("mdl adel8", {31'b0, adel8}, {31'b0, m_adel[1]});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        exc_valid = 0; eret_valid = 0; br_valid = 0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #1 resetn = 0;
        repeat (3) step();
        chk("rst pc", pc4, 32'hbfc00000);
        chk("rst red", {31'b0, red4}, 32'd0);
        chk("rst pend", {31'b0, pv4}, 32'd0);
        chk("rst adel", {31'b0, adel4}, 32'd0);
        resetn = 1;
        #1 chk("post-rst pc", pc4, 32'hbfc00000);
        step(); chk("adv1", pc4, 32'hbfc00004); chk("adv1 red", {31'b0, red4}, 32'd0);
        step(); chk("adv2", pc4, 32'hbfc00008); chk("adv2 fb8", pc8, 32'hbfc00010);

        // all three sources at once
        exc_valid = 1; exc_target = 32'hbfc00380;
        eret_valid = 1; eret_target = 32'h80001000;
        br_valid = 1; br_target = 32'h80002000;
        step(); clr_req();
        chk("prio pc", pc4, 32'hbfc00380); chk("prio red", {31'b0, red4}, 32'd1);
        step();
        chk("prio next", pc4, 32'hbfc00384); chk("prio red off", {31'b0, red4}, 32'd0);

        // stall capture: br, exc, lower-rank br must not overwrite
        stall = 1;
        br_valid = 1; br_target = 32'h80002000; step(); clr_req();
        chk("stl pend", {31'b0, pv4}, 32'd1); chk("stl hold", pc4, 32'hbfc00384);
        exc_valid = 1; exc_target = 32'hbfc00380; step(); clr_req();
        br_valid = 1; br_target = 32'h80003000; step(); clr_req();
        chk("stl hold2", pc4, 32'hbfc00384); chk("stl red", {31'b0, red4}, 32'd0);
        step();
        stall = 0; step();
        chk("stl rel pc", pc4, 32'hbfc00380); chk("stl rel red", {31'b0, red4}, 32'd1);
        chk("stl rel pend", {31'b0, pv4}, 32'd0);
        step(); chk("stl rel adv", pc4, 32'hbfc00384);

        // equal rank under stall: newer wins
        stall = 1;
        br_valid = 1; br_target = 32'h80004000; step();
        br_target = 32'h80005000; step(); clr_req();
        stall = 0; step();
        chk("eq rank newer", pc4, 32'h80005000);

        // wrap-around
        br_valid = 1; br_target = 32'hfffffff8; step(); clr_req();
        chk("wrap ld4", pc4, 32'hfffffff8);
        step();
        chk("wrap fb8", pc8, 32'h00000000); chk("wrap4 mid", pc4, 32'hfffffffc);
        chk("wrap red", {31'b0, red8}, 32'd0);
        step(); chk("wrap fb4", pc4, 32'h00000000);

        // reset while a redirect is pending
        stall = 1;
        eret_valid = 1; eret_target = 32'h80001234; step(); clr_req();
        chk("mid pend", {31'b0, pv4}, 32'd1);
        #1 resetn = 0;
        #1 chk("async pend", {31'b0, pv4}, 32'd0); chk("async pc", pc4, 32'hbfc00000);
        step(); resetn = 1; stall = 0;
        step(); chk("rst rel adv", pc4, 32'hbfc00004);

        // alignment
        br_valid = 1; br_target = 32'h80000002; step(); clr_req();
        chk("al pc", pc4, 32'h80000002);
        chk("al adel", {31'b0, adel4}, {31'b0, ALIGN_EN});
        stall = 1; step();
        chk("al hold", {31'b0, adel4}, {31'b0, ALIGN_EN});
        stall = 0; step();
        chk("al clr", {31'b0, adel4}, 32'd0); chk("al adv", pc4, 32'h80000006);
        br_valid = 1; br_target = 32'h80000100; step(); clr_req();
        chk("al aligned", {31'b0, adel4}, 32'd0);

        repeat (3) step();
        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-PC generator for the Loongson core front end; successor to the single-register PC. It holds the fetch address, advances it by `FETCH_BYTES` per unstalled cycle and applies redirects from three sources: exception, ERET and branch. Each source has a fixed priority. A redirect that arrives while fetch is stalled is captured in a one-entry pending slot and applied on the first unstalled cycle, so it is never lost. It sits between the redirect logic in EX/WB and the instruction-fetch stage.

## Interface
Parameters:
- `ADDR_W`, 32, width of all addresses.
- `RESET_VECTOR`, 32'hbfc00000, value of `pc_out` during and after reset.
- `FETCH_BYTES`, 4, sequential increment; a power of two, 4 or 8.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `stall`  in  1  1 = hold `pc_out`; redirects are captured into the pending slot.
- `exc_valid`  in  1  exception redirect request (rank 3).
- `exc_target`  in  ADDR_W  exception handler address.
- `eret_valid`  in  1  ERET redirect request (rank 2).
- `eret_target`  in  ADDR_W  EPC value.
- `br_valid`  in  1  branch/jump redirect request (rank 1).
- `br_target`  in  ADDR_W  branch target.
- `pc_out`  out  ADDR_W  current fetch address (registered).
- `redirected`  out  1  registered one-cycle pulse: `pc_out` was just loaded from a redirect.
- `pend_valid`  out  1  pending slot occupied.
- `pc_adel`  out  1  registered misaligned-fetch flag (see Configuration).

## Operation
- Reset (`resetn`=0, asynchronous) forces these values:
  - `pc_out`=RESET_VECTOR
  - `redirected`=0, `pend_valid`=0, `pc_adel`=0
  - pending rank=0, pending target=0
- Current request rank: the highest asserted of exc (3), eret (2), br (1); 0 if none.
- Candidate selection:
  - Compare the current request rank with the pending rank; the higher rank wins.
  - On equal non-zero rank, the current request wins, because it is newer.
- When `stall`=1:
  - `pc_out` holds.
  - If the candidate comes from the current request, the pending slot is loaded with that rank and target. Otherwise the slot is unchanged.
  - A lower-rank request never overwrites a higher-rank pending entry.
  - `redirected` is 0.
- When `stall`=0 and a candidate exists (rank ≠ 0):
  - `pc_out` is loaded with the candidate target.
  - `redirected` is 1 the next cycle.
  - The pending slot is cleared.
- When `stall`=0 and there is no candidate: `pc_out` ← `pc_out` + FETCH_BYTES, modulo 2^ADDR_W. It wraps from all-ones minus (FETCH_BYTES−1) to 0 with no flag.
- Targets load unmodified; there is no alignment masking.

## Timing
- Redirect latency when unstalled: request in cycle N → `pc_out`=target in cycle N+1, with `redirected`=1 in N+1 only.
- Redirect under stall: request in cycle N with `stall`=1 → `pend_valid`=1 from N+1. The first cycle M with `stall`=0 loads the target; `pc_out` and `redirected` update in M+1, and `pend_valid`=0 in M+1.
- Request valids are sampled every cycle. A request held for several cycles is equivalent to a single-cycle one.
- Reset assertion mid-operation discards any pending redirect immediately. After `resetn` rises, the first unstalled edge yields RESET_VECTOR+FETCH_BYTES.
- No combinational path from any input to any output.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - `pc_adel` is registered alongside `pc_out`.
  - It is 1 when the newly loaded redirect target has any of its low log2(FETCH_BYTES) bits non-zero.
  - It clears on the next sequential advance or on an aligned redirect, and holds while stalled.
  - The pending slot stores the target as-is; the check is done at load.
- Not defined: `pc_adel` is constant 0 and no check logic is generated.

## Test plan
- Reset/advance: `resetn` low for 3 cycles, then high with `stall`=0 → `pc_out` 0xbfc00000, 0xbfc00004, 0xbfc00008 on consecutive cycles; `redirected`=0 throughout.
- Priority: `exc_valid`, `eret_valid` and `br_valid` all pulsed together with targets 0xbfc00380/0x80001000/0x80002000 → next `pc_out`=0xbfc00380 with a one-cycle `redirected` pulse.
- Stall capture:
  - With `stall`=1, pulse `br_valid` (target 0x80002000), then `exc_valid` (0xbfc00380), then `br_valid` (0x80003000).
  - `pend_valid`=1 and `pc_out` held throughout.
  - Release `stall` → `pc_out`=0xbfc00380, then 0xbfc00384.
- Wrap-around: with ADDR_W=32 and FETCH_BYTES=8, redirect to 0xfffffff8 → the next unstalled cycle gives `pc_out`=0x00000000.
- Reset mid-pending: capture an ERET to 0x80001234 under stall, assert `resetn`=0 for 1 cycle → `pend_valid`=0 and `pc_out`=0xbfc00000 asynchronously; release `stall` → 0xbfc00004.
- Alignment (`PC_ALIGN_CHECK_EN` builds only): `br_target`=0x80000002 → `pc_adel`=1 with `pc_out`=0x80000002; next advance → `pc_adel`=0. With the macro undefined, `pc_adel` stays 0.
